// File: rtl/seq_detect_moore_p.sv
// Moore-type serial pattern detector with a programmable PAT_W-bit pattern.
// It uses a KMP-style prefix fallback, an overlap mode, pattern reload and a saturating match count.
module seq_detect_moore_p #(
    parameter int                 PAT_W    = 4,
    parameter logic [PAT_W-1:0]   PAT_INIT = 4'b1011,
    parameter int                 CNT_W    = 8,
    localparam int                ST_W     = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             x_in,
    input  logic             x_valid,
    input  logic             overlap,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    output logic             y_out,
    output logic [ST_W-1:0]  state_idx,
    output logic [CNT_W-1:0] match_cnt,
    output logic [PAT_W-1:0] pattern
);

    localparam logic [ST_W-1:0] FULL = ST_W'(PAT_W);

    // Longest prefix of pat that is a suffix of (prefix_k, b), capped at PAT_W.
    // The newest bit sits at position 0 of each vector, so prefixes are compared after a right shift.
    function automatic logic [ST_W-1:0] kmp_next(
        input logic [ST_W-1:0]  k,
        input logic             b,
        input logic [PAT_W-1:0] pat
    );
        logic [PAT_W:0]  pat_x;
        logic [PAT_W:0]  seen;
        logic [PAT_W:0]  mask;
        logic [PAT_W:0]  pre_j;
        logic [ST_W-1:0] best;
        pat_x = {1'b0, pat};
        seen  = ((pat_x >> (PAT_W - int'(k))) << 1) | (PAT_W + 1)'(b);
        best  = '0;
        for (int j = 1; j <= PAT_W; j++) begin
            mask  = ((PAT_W + 1)'(1) << j) - (PAT_W + 1)'(1);
            pre_j = pat_x >> (PAT_W - j);
            if ((j <= int'(k) + 1) && ((seen & mask) == pre_j)) begin
                best = ST_W'(j);
            end
        end
        return best;
    endfunction

    logic [ST_W-1:0] from_idx;
    logic [ST_W-1:0] next_idx;

    always_comb begin
        // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
        from_idx = state_idx;
        if (state_idx == FULL && !overlap) begin
            from_idx = '0;
        end
        next_idx = kmp_next(from_idx, x_in, pattern);
    end

    // NOTE: all state here is updated with <=, so every register samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_idx <= '0;
            y_out     <= 1'b0;
            match_cnt <= '0;
            pattern   <= PAT_INIT;
        end else if (pat_load) begin
            pattern   <= pat_in;
            state_idx <= '0;
            y_out     <= 1'b0;
        end else if (x_valid) begin
            state_idx <= next_idx;
            y_out     <= (next_idx == FULL);
            if (next_idx == FULL && match_cnt != {CNT_W{1'b1}}) begin
                match_cnt <= match_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_moore_p.sv
// Scoreboard bench for seq_detect_moore_p: a 4-bit instance and a degenerate 1-bit/2-bit-counter instance.
// The reference model keeps the received bit history and finds the longest suffix that is a pattern prefix.
module tb_seq_detect_moore_p;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       a_x = 1'b0, a_valid = 1'b0, a_ov = 1'b0, a_load = 1'b0;
    logic [3:0] a_pin = 4'b0;
    logic       a_y;
    logic [2:0] a_st;
    logic [7:0] a_cnt;
    logic [3:0] a_pat;

    logic       b_x = 1'b0, b_valid = 1'b0, b_ov = 1'b0, b_load = 1'b0;
    logic [0:0] b_pin = 1'b0;
    logic       b_y;
    logic [0:0] b_st;
    logic [1:0] b_cnt;
    logic [0:0] b_pat;

    seq_detect_moore_p #(.PAT_W(4), .PAT_INIT(4'b1011), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .x_in(a_x), .x_valid(a_valid), .overlap(a_ov),
        .pat_load(a_load), .pat_in(a_pin), .y_out(a_y), .state_idx(a_st),
        .match_cnt(a_cnt), .pattern(a_pat)
    );

    seq_detect_moore_p #(.PAT_W(1), .PAT_INIT(1'b1), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .x_in(b_x), .x_valid(b_valid), .overlap(b_ov),
        .pat_load(b_load), .pat_in(b_pin), .y_out(b_y), .state_idx(b_st),
        .match_cnt(b_cnt), .pattern(b_pat)
    );

    typedef struct {
        int          st;
        int          cnt;
        int          hlen;
        logic [15:0] hist;
        logic [15:0] pat;
    } model_t;

    typedef struct {
        logic        y;
        int          st;
        int          cnt;
        logic [15:0] pat;
    } exp_t;

    model_t ma, mb;
    exp_t   q_a[$];
    exp_t   q_b[$];
    int     checks = 0;
    int     errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Do the last j history bits (newest at bit 0) spell the first j pattern bits?
    function automatic bit suffix_is_prefix(input logic [15:0] hist, input logic [15:0] pat,
                                            input int pw, input int j);
        logic [15:0] h;
        logic [15:0] p;
        for (int i = 0; i < j; i++) begin
            h = hist >> i;
            p = pat >> (pw - j + i);
            if (h[0] !== p[0]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic model_t model_step(input model_t m, input int pw, input int cmax,
                                          input logic [15:0] pinit, input logic r, input logic ld,
                                          input logic [15:0] pin, input logic v, input logic x,
                                          input logic ov);
        model_t n;
        n = m;
        if (r) begin
            n.st = 0; n.cnt = 0; n.hlen = 0; n.hist = '0; n.pat = pinit;
        end else if (ld) begin
            n.pat = pin; n.st = 0; n.hlen = 0;
        end else if (v) begin
            if (m.st == pw && !ov) n.hlen = 0;
            n.hist = {m.hist[14:0], x};
            n.hlen = (n.hlen < pw) ? n.hlen + 1 : pw;
            n.st = 0;
            for (int j = 1; j <= pw; j++) begin
                if (j <= n.hlen && suffix_is_prefix(n.hist, n.pat, pw, j)) n.st = j;
            end
            if (n.st == pw && n.cnt < cmax) n.cnt++;
        end
        return n;
    endfunction

    task automatic tick();
        exp_t e;
        @(posedge clk);
        ma = model_step(ma, 4, 255, 16'hB, rst, a_load, {12'b0, a_pin}, a_valid, a_x, a_ov);
        mb = model_step(mb, 1, 3, 16'h1, rst, b_load, {15'b0, b_pin}, b_valid, b_x, b_ov);
        e.y = (ma.st == 4); e.st = ma.st; e.cnt = ma.cnt; e.pat = ma.pat;
        q_a.push_back(e);
        e.y = (mb.st == 1); e.st = mb.st; e.cnt = mb.cnt; e.pat = mb.pat;
        q_b.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: the DUT presents a fresh output every cycle, compare it mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q_a.size() > 0) begin
            e = q_a.pop_front();
            check("a_y_out", 32'(a_y), 32'(e.y));
            check("a_state_idx", 32'(a_st), e.st);
            check("a_match_cnt", 32'(a_cnt), e.cnt);
            check("a_pattern", 32'(a_pat), 32'(e.pat));
        end
        if (q_b.size() > 0) begin
            e = q_b.pop_front();
            check("b_y_out", 32'(b_y), 32'(e.y));
            check("b_state_idx", 32'(b_st), e.st);
            check("b_match_cnt", 32'(b_cnt), e.cnt);
            check("b_pattern", 32'(b_pat), 32'(e.pat));
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic send_a(input logic x, input logic ov);
        a_valid = 1'b1; a_x = x; a_ov = ov;
        tick();
        a_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int ovl_seq[7];
        int non_seq[7];
        int sat_seq[6];
        logic [6:0] stream;
        ovl_seq = '{1, 2, 3, 4, 2, 3, 4};
        non_seq = '{1, 2, 3, 4, 0, 1, 1};
        sat_seq = '{1, 2, 3, 3, 3, 3};
        stream  = 7'b1011011;

        // Reset held two cycles with a valid 1 on the wire.
        @(negedge clk);
        rst = 1'b1; a_valid = 1'b1; a_x = 1'b1; b_valid = 1'b1; b_x = 1'b1;
        tick(); tick();
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        check("rst_y_out", 32'(a_y), 32'd0);
        check("rst_state_idx", 32'(a_st), 32'd0);
        check("rst_match_cnt", 32'(a_cnt), 32'd0);
        check("rst_pattern", 32'(a_pat), 32'b1011);

        // Overlapping matches.
        for (int i = 0; i < 7; i++) begin
            send_a(stream[6 - i], 1'b1);
            check("ovl_state_idx", 32'(a_st), ovl_seq[i]);
            check("ovl_y_out", 32'(a_y), 32'(ovl_seq[i] == 4));
        end
        check("ovl_match_cnt", 32'(a_cnt), 32'd2);

        // Non-overlapping matches.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            send_a(stream[6 - i], 1'b0);
            check("novl_state_idx", 32'(a_st), non_seq[i]);
        end
        check("novl_match_cnt", 32'(a_cnt), 32'd1);

        // Stall holds the match state and the counter.
        do_reset();
        for (int i = 0; i < 4; i++) send_a(stream[6 - i], 1'b1);
        check("stall_y_first", 32'(a_y), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_y_hold", 32'(a_y), 32'd1);
            check("stall_cnt_hold", 32'(a_cnt), 32'd1);
        end
        send_a(1'b0, 1'b1);
        check("stall_leave_state", 32'(a_st), 32'd2);
        check("stall_leave_y", 32'(a_y), 32'd0);

        // Mid-match reset discards everything.
        send_a(1'b1, 1'b1); send_a(1'b1, 1'b1);
        rst = 1'b1; a_valid = 1'b1; a_x = 1'b1;
        tick();
        rst = 1'b0; a_valid = 1'b0;
        check("midrst_state_idx", 32'(a_st), 32'd0);

        // Reload mid-prefix; the bit offered with pat_load is discarded.
        for (int i = 0; i < 3; i++) send_a(stream[6 - i], 1'b1);
        check("reload_pre_state", 32'(a_st), 32'd3);
        a_load = 1'b1; a_pin = 4'b0110; a_valid = 1'b1; a_x = 1'b0;
        tick();
        a_load = 1'b0; a_valid = 1'b0;
        check("reload_state_idx", 32'(a_st), 32'd0);
        check("reload_pattern", 32'(a_pat), 32'b0110);
        send_a(1'b0, 1'b1); send_a(1'b1, 1'b1); send_a(1'b1, 1'b1); send_a(1'b0, 1'b1);
        check("reload_match_y", 32'(a_y), 32'd1);
        rst = 1'b1; a_load = 1'b1; a_pin = 4'b0110;
        tick();
        rst = 1'b0; a_load = 1'b0;
        check("rst_over_load_pattern", 32'(a_pat), 32'b1011);

        // Degenerate 1-bit pattern with a saturating 2-bit counter.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            b_valid = 1'b1; b_x = 1'b1; b_ov = 1'b1;
            tick();
            check("sat_y_out", 32'(b_y), 32'd1);
            check("sat_match_cnt", 32'(b_cnt), sat_seq[i]);
        end
        b_valid = 1'b0;

        // Randomised traffic on both instances.
        for (int n = 0; n < 3000; n++) begin
            rst     = ($urandom_range(0, 399) == 0);
            a_load  = ($urandom_range(0, 63) == 0);
            a_pin   = 4'($urandom);
            a_valid = ($urandom_range(0, 3) != 0);
            a_x     = 1'($urandom);
            a_ov    = 1'($urandom);
            b_load  = ($urandom_range(0, 31) == 0);
            b_pin   = 1'($urandom);
            b_valid = ($urandom_range(0, 3) != 0);
            b_x     = ($urandom_range(0, 3) != 0);
            b_ov    = 1'($urandom);
            tick();
        end
        rst = 1'b0; a_load = 1'b0; a_valid = 1'b0; b_load = 1'b0; b_valid = 1'b0;

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(q_a.size() + q_b.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
